// File: rtl/matrix_ram_arbiter.sv
// Single-port operand/result RAM owner for the matrix multiplier: host load/unload while idle,
// header validation on host_go, then hand-off to matrix_mul_cu under a watchdog.
module matrix_ram_arbiter #(
  parameter int data_w    = 32,
  parameter int ram_d     = 512,
  parameter int ram_add_w = $clog2(ram_d),
  parameter int timeout_w = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ram_add_w-1:0] host_addr,
  input  logic [data_w-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [data_w-1:0]    host_rdata,
  input  logic                 host_go,
  output logic                 host_busy,
  output logic                 host_done,
  output logic                 host_err,
  output logic [1:0]           err_code,
  output logic                 cu_start,
  output logic                 cu_rst,
  input  logic                 cu_done,
  input  logic                 cu_err,
  input  logic                 cu_ram_we,
  input  logic [ram_add_w-1:0] cu_ram_addr,
  input  logic [data_w-1:0]    cu_ram_w_data,
  output logic                 ram_we,
  output logic [ram_add_w-1:0] ram_addr,
  output logic [data_w-1:0]    ram_w_data,
  input  logic [data_w-1:0]    ram_r_data,
  output logic [2:0]           dbg_state
);

  localparam int fld_w = data_w / 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_RD  = 3'd1,
    HDR_CHK = 3'd2,
    LAUNCH  = 3'd3,
    RUN     = 3'd4,
    ABORT   = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [timeout_w-1:0] wd_cnt;
  logic [1:0]           blank_cnt;
  logic                 abort_cnt;
  logic                 err_set, done_set;
  logic [1:0]           err_val;
  logic [19:0]          m1, n1, m2, n2, cap;
  logic                 dim_bad, cap_bad, masked, wd_full;

  // Host handshake: host_req is a level the host holds until host_gnt; an access is
  // accepted in every cycle where both are high, and only while IDLE.
  assign host_gnt   = host_req & (state == IDLE);
  assign host_busy  = (state != IDLE);
  assign cu_start   = (state == LAUNCH);
  assign cu_rst     = (state == ABORT);
  assign host_rdata = ram_r_data;
  assign dbg_state  = state;

  // Header fields arrive on ram_r_data during HDR_CHK (address 0 was presented in HDR_RD).
  assign m1 = 20'(ram_r_data[4*fld_w-1 -: fld_w]);
  assign n1 = 20'(ram_r_data[3*fld_w-1 -: fld_w]);
  assign m2 = 20'(ram_r_data[2*fld_w-1 -: fld_w]);
  assign n2 = 20'(ram_r_data[fld_w-1 -: fld_w]);

  assign dim_bad = (n1 != m2) | (m1 == 20'd0) | (n1 == 20'd0) | (m2 == 20'd0) | (n2 == 20'd0);
  assign cap     = 20'd2 + m1 * n1 + m2 * n2
                 + (m1 + {19'd0, m1[0]}) * (n2 + {19'd0, n2[0]});
  assign cap_bad = cap > 20'(ram_d);

  // The CU's done level from the previous run is still high for the first RUN cycles.
  assign masked  = blank_cnt < 2'd2;
  assign wd_full = &wd_cnt;

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_val   = 2'd0;
    done_set  = 1'b0;
    case (state)
      IDLE:    if (host_go) state_nxt = HDR_RD;
      HDR_RD:  state_nxt = HDR_CHK;
      HDR_CHK: begin
        if (dim_bad) begin
          err_set   = 1'b1;
          err_val   = 2'd1;
          state_nxt = IDLE;
        end else if (cap_bad) begin
          err_set   = 1'b1;
          err_val   = 2'd2;
          state_nxt = IDLE;
        end else begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:  state_nxt = RUN;
      RUN: begin
        if (!masked && cu_err) begin
          err_set   = 1'b1;
          err_val   = 2'd1;
          state_nxt = IDLE;
        end else if (!masked && cu_done) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end else if (wd_full) begin
          err_set   = 1'b1;
          err_val   = 2'd3;
          state_nxt = ABORT;
        end
      end
      ABORT:   if (abort_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    case (state)
      IDLE: begin
        ram_we     = host_we & host_gnt;
        ram_addr   = host_addr;
        ram_w_data = host_wdata;
      end
      LAUNCH, RUN: begin
        ram_we     = cu_ram_we;
        ram_addr   = cu_ram_addr;
        ram_w_data = cu_ram_w_data;
      end
      default: begin
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_w_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      blank_cnt   <= 2'd0;
      abort_cnt   <= 1'b0;
      host_rvalid <= 1'b0;
      host_done   <= 1'b0;
      host_err    <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      state       <= state_nxt;
      host_rvalid <= host_gnt & ~host_we;
      host_done   <= done_set;
      abort_cnt   <= (state == ABORT) ? ~abort_cnt : 1'b0;
      if (state == RUN) begin
        if (!wd_full) wd_cnt <= wd_cnt + timeout_w'(1);
        if (masked) blank_cnt <= blank_cnt + 2'd1;
      end else begin
        wd_cnt    <= '0;
        blank_cnt <= 2'd0;
      end
      if ((state == IDLE) && host_go) begin
        host_err <= 1'b0;
        err_code <= 2'd0;
      end else if (err_set) begin
        host_err <= 1'b1;
        err_code <= err_val;
      end
    end
  end

endmodule

// File: tb/tb_matrix_ram_arbiter.sv
// Bench for matrix_ram_arbiter: a timeline model counted from the host_go edge predicts every
// output each cycle, alongside directed checks with hand-computed cycle numbers and codes.
module tb_matrix_ram_arbiter;

  localparam int data_w    = 32;
  localparam int ram_d     = 512;
  localparam int ram_add_w = 9;
  localparam int timeout_w = 6;
  localparam int wd_max    = (1 << timeout_w) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 host_req, host_we, host_go;
  logic [ram_add_w-1:0] host_addr;
  logic [data_w-1:0]    host_wdata;
  logic                 host_gnt, host_rvalid, host_busy, host_done, host_err;
  logic [data_w-1:0]    host_rdata;
  logic [1:0]           err_code;
  logic                 cu_start, cu_rst, cu_done, cu_err, cu_ram_we;
  logic [ram_add_w-1:0] cu_ram_addr;
  logic [data_w-1:0]    cu_ram_w_data;
  logic                 ram_we;
  logic [ram_add_w-1:0] ram_addr;
  logic [data_w-1:0]    ram_w_data;
  logic [data_w-1:0]    ram_r_data;
  logic [2:0]           dbg_state;

  matrix_ram_arbiter #(
    .data_w(data_w), .ram_d(ram_d), .ram_add_w(ram_add_w), .timeout_w(timeout_w)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_go(host_go), .host_busy(host_busy), .host_done(host_done),
    .host_err(host_err), .err_code(err_code),
    .cu_start(cu_start), .cu_rst(cu_rst), .cu_done(cu_done), .cu_err(cu_err),
    .cu_ram_we(cu_ram_we), .cu_ram_addr(cu_ram_addr), .cu_ram_w_data(cu_ram_w_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM behind the arbiter ----------------
  logic [data_w-1:0] mem [ram_d];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_w_data;
    ram_r_data <= mem[ram_addr];
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0, done_cnt = 0, rst_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [data_w-1:0] shadow [ram_d];
  logic              m_idle = 1'b1;
  int                m_t = 0;
  int                m_abort_at = 0;
  logic              e_done = 1'b0, e_err = 1'b0, e_rvalid = 1'b0;
  logic [1:0]        e_code = 2'd0;
  logic [data_w-1:0] e_rdata = '0;

  function automatic int verdict(input logic [31:0] h);
    int m1, n1, m2, n2, need;
    m1 = int'(h[31:24]);
    n1 = int'(h[23:16]);
    m2 = int'(h[15:8]);
    n2 = int'(h[7:0]);
    if (n1 != m2 || m1 == 0 || n1 == 0 || m2 == 0 || n2 == 0) return 1;
    need = 2 + m1 * n1 + m2 * n2 + ((m1 + 1) / 2 * 2) * ((n2 + 1) / 2 * 2);
    return (need > ram_d) ? 2 : 0;
  endfunction

  // m_t is the number of cycles since the accepted host_go edge; the outcome of a run is
  // decided by counting RUN cycles (cycle 4 onward) against the CU levels and the watchdog.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_t = 0; m_abort_at = 0;
      e_done = 1'b0; e_err = 1'b0; e_code = 2'd0; e_rvalid = 1'b0;
    end else begin
      e_done   = 1'b0;
      e_rvalid = 1'b0;
      if (m_idle) begin
        if (host_req) begin
          if (host_we) shadow[host_addr] = host_wdata;
          else begin
            e_rvalid = 1'b1;
            e_rdata  = shadow[host_addr];
          end
        end
        if (host_go) begin
          m_idle = 1'b0; m_t = 1; m_abort_at = 0;
          e_err = 1'b0; e_code = 2'd0;
        end
      end else if (m_t == 2) begin
        if (verdict(shadow[0]) != 0) begin
          m_idle = 1'b1; e_err = 1'b1; e_code = 2'(verdict(shadow[0]));
        end else m_t = 3;
      end else if (m_abort_at != 0) begin
        if (m_t == m_abort_at + 1) m_idle = 1'b1;
        else m_t++;
      end else if (m_t >= 6 && cu_err) begin
        m_idle = 1'b1; e_err = 1'b1; e_code = 2'd1;
      end else if (m_t >= 6 && cu_done) begin
        m_idle = 1'b1; e_done = 1'b1;
      end else if (m_t >= 4 && m_t - 4 == wd_max) begin
        m_abort_at = m_t + 1; m_t++;
        e_err = 1'b1; e_code = 2'd3;
      end else begin
        m_t++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic cu_owns;
    forever begin
      @(posedge clk); #1;
      cu_owns = !m_idle && m_abort_at == 0 && m_t >= 3;
      check("host_busy",   32'(host_busy),   32'(!m_idle));
      check("host_gnt",    32'(host_gnt),    32'(host_req && m_idle));
      check("cu_start",    32'(cu_start),    32'(!m_idle && m_t == 3));
      check("cu_rst",      32'(cu_rst),      32'(!m_idle && m_abort_at != 0));
      check("host_done",   32'(host_done),   32'(e_done));
      check("host_err",    32'(host_err),    32'(e_err));
      check("err_code",    32'(err_code),    32'(e_code));
      check("host_rvalid", 32'(host_rvalid), 32'(e_rvalid));
      if (e_rvalid) check("host_rdata", host_rdata, e_rdata);
      if (m_idle) begin
        check("ram_we_host",   32'(ram_we),   32'(host_req && host_we));
        check("ram_addr_host", 32'(ram_addr), 32'(host_addr));
        if (host_req && host_we) check("ram_wdata_host", ram_w_data, host_wdata);
      end else if (cu_owns) begin
        check("ram_we_cu",    32'(ram_we),   32'(cu_ram_we));
        check("ram_addr_cu",  32'(ram_addr), 32'(cu_ram_addr));
        check("ram_wdata_cu", ram_w_data,    cu_ram_w_data);
      end else begin
        check("ram_we_arb",   32'(ram_we),   32'd0);
        check("ram_addr_arb", 32'(ram_addr), 32'd0);
      end
      start_cnt += int'(cu_start);
      done_cnt  += int'(host_done);
      rst_cnt   += int'(cu_rst);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic [ram_add_w-1:0] a, input logic [data_w-1:0] d);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input string name, input logic [ram_add_w-1:0] a,
                           input logic [data_w-1:0] exp);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    @(posedge clk); #1;
    check({name, "_rvalid"}, 32'(host_rvalid), 32'd1);
    check({name, "_rdata"}, host_rdata, exp);
    @(negedge clk);
    host_req = 1'b0;
  endtask

  // Leaves the caller in the middle of cycle 1 (host_go sampled at edge 0).
  task automatic pulse_go();
    @(negedge clk);
    host_go = 1'b1;
    @(negedge clk);
    host_go = 1'b0;
  endtask

  // sel 0: cu_start, 1: host_busy low, 2: host_done. cycles = index of the cycle seen.
  task automatic wait_sig(input int sel, input int max, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if ((sel == 0 && cu_start) || (sel == 1 && !host_busy) || (sel == 2 && host_done)) begin
        cycles = i + 1;
        break;
      end
    end
    if (cycles < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_sig%0d: event not seen within %0d cycles", sel, max);
    end
  endtask

  task automatic header_reject(input string name, input logic [31:0] hdr, input logic [1:0] code);
    host_write(0, hdr);
    start_cnt = 0;
    pulse_go();
    @(posedge clk); @(posedge clk); #1;
    check({name, "_err_c3"},  32'(host_err),  32'd1);
    check({name, "_code_c3"}, 32'(err_code),  32'(code));
    check({name, "_busy_c3"}, 32'(host_busy), 32'd0);
    check({name, "_nostart"}, 32'(start_cnt), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_go = 1'b0;
    cu_done = 1'b0; cu_err = 1'b0;
    cu_ram_we = 1'b1; cu_ram_addr = 9'h1F0; cu_ram_w_data = 32'hC0DE_0001;

    repeat (3) @(negedge clk);
    check("rst_busy",  32'(host_busy),   32'd0);
    check("rst_err",   32'(host_err),    32'd0);
    check("rst_code",  32'(err_code),    32'd0);
    check("rst_state", 32'(dbg_state),   32'd0);
    check("rst_start", 32'(cu_start),    32'd0);
    rst_n = 1'b1;

    // Load: header plus eight operand words, then read back.
    host_write(0, 32'h0202_0202);
    for (int i = 1; i <= 8; i++) host_write(9'(i), 32'h100 + 32'(i));
    host_read("rd_hdr", 0, 32'h0202_0202);
    host_read("rd_op5", 5, 32'h0000_0105);

    header_reject("dim_n1m2", 32'h0203_0202, 2'd1);
    header_reject("dim_zero", 32'h0202_0200, 2'd1);
    header_reject("cap_770",  32'h1010_1010, 2'd2);

    // Valid 2x2 run with a stale done level at launch; host keeps requesting a read.
    host_write(0, 32'h0202_0202);
    cu_done = 1'b1;
    start_cnt = 0; done_cnt = 0;
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 0;
    pulse_go();
    wait_sig(0, 10, cyc);
    check("run_start_cycle", 32'(cyc), 32'd3);
    check("run_err_cleared", 32'(host_err), 32'd0);
    repeat (4) @(negedge clk);
    cu_done = 1'b0;
    repeat (36) @(negedge clk);
    cu_done = 1'b1;
    wait_sig(2, 20, cyc);
    repeat (3) @(posedge clk); #1;
    check("run_one_start", 32'(start_cnt), 32'd1);
    check("run_one_done",  32'(done_cnt),  32'd1);
    check("run_no_err",    32'(host_err),  32'd0);
    @(negedge clk);
    host_req = 1'b0;

    // CU error held with stale done: masked for two RUN cycles, then error wins.
    cu_err = 1'b1;
    done_cnt = 0;
    pulse_go();
    wait_sig(1, 20, cyc);
    check("cuerr_idle_cycle", 32'(cyc), 32'd7);
    check("cuerr_code",       32'(err_code), 32'd1);
    check("cuerr_no_done",    32'(done_cnt), 32'd0);
    @(negedge clk);
    cu_err = 1'b0; cu_done = 1'b0;

    // Watchdog: 64 RUN cycles (cycles 4..67), ABORT in 68..69, IDLE at 70.
    rst_cnt = 0;
    pulse_go();
    wait_sig(1, 200, cyc);
    check("wd_idle_cycle", 32'(cyc), 32'd70);
    check("wd_code",       32'(err_code), 32'd3);
    check("wd_rst_cycles", 32'(rst_cnt), 32'd2);
    host_read("wd_rd_hdr", 0, 32'h0202_0202);

    // Asynchronous reset mid-RUN.
    pulse_go();
    wait_sig(0, 10, cyc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(host_busy), 32'd0);
    check("arst_err",   32'(host_err),  32'd0);
    check("arst_code",  32'(err_code),  32'd0);
    check("arst_start", 32'(cu_start),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 0;
    #1;
    check("arst_gnt", 32'(host_gnt), 32'd1);
    @(posedge clk); #1;
    check("arst_rvalid", 32'(host_rvalid), 32'd1);
    check("arst_rdata",  host_rdata, 32'h0202_0202);
    @(negedge clk);
    host_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
